// File: rtl/aud_rmm_seq.sv
// Sequencer for multi-word RMM block transfers over the AUD port.
// Moves one 32-bit word per engine handshake, with per-phase timeout and word-boundary abort.
module aud_rmm_seq #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024,
    parameter int TMR_W   = 11
) (
    input  logic             clk_sys_i,
    input  logic             rst_n_i,
    input  logic             cmd_start_i,
    input  logic             cmd_dir_i,
    input  logic [31:0]      cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             cmd_abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       err_code_o,
    output logic [LEN_W-1:0] words_done_o,
    input  logic [31:0]      wf_dat_i,
    input  logic             wf_empty_i,
    output logic             wf_rd_o,
    output logic [31:0]      rf_dat_o,
    input  logic             rf_full_i,
    output logic             rf_wr_o,
    output logic [31:0]      rmm_addr_o,
    output logic [31:0]      rmm_data_o,
    output logic             rmm_we_o,
    output logic             rmm_re_o,
    input  logic [31:0]      rmm_data_i,
    input  logic             rmm_idle_i,
    input  logic             rmm_err_i
);

    // state  | meaning
    // IDLE   | waiting for a start command
    // FETCH  | word boundary: abort check, wait for FIFO data/space and idle engine
    // ISSUE  | one-cycle engine strobe
    // ACCEPT | waiting for the engine to leave idle
    // ACTIVE | waiting for the engine to complete or flag an error
    // STORE  | push read word into the read FIFO
    // FINISH | done pulse, result codes final
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_ACCEPT, S_ACTIVE, S_STORE, S_FINISH
    } state_t;

    // The down-counter is loaded on the cycle a phase starts, so a phase spans TIMEOUT cycles
    // counted from its opening event (strobe, or idle-drop) and expires at terminal count 1.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    state_t           r_state, w_state_nxt;
    logic             r_dir, r_abort;
    logic [31:0]      r_addr, r_wdat, r_rdat;
    logic [LEN_W-1:0] r_len, r_words;
    logic [1:0]       r_err;
    logic [TMR_W-1:0] r_tmr;
    logic             w_tmo, w_last, w_wr_ok, w_rd_ok;

    assign w_tmo   = (r_tmr == TMR_ONE);
    assign w_last  = ((r_words + LEN_W'(1)) == r_len);
    assign w_wr_ok = r_dir && !wf_empty_i && rmm_idle_i;
    assign w_rd_ok = !r_dir && !rf_full_i && rmm_idle_i;

    assign busy_o       = (r_state != S_IDLE);
    assign err_code_o   = r_err;
    assign words_done_o = r_words;
    assign rmm_addr_o   = r_addr;
    assign rmm_data_o   = r_wdat;
    assign rf_dat_o     = r_rdat;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        done_o      = 1'b0;
        wf_rd_o     = 1'b0;
        rf_wr_o     = 1'b0;
        rmm_we_o    = 1'b0;
        rmm_re_o    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_start_i) w_state_nxt = (cmd_len_i == '0) ? S_FINISH : S_FETCH;
            end
            S_FETCH: begin
                if (r_abort) begin
                    w_state_nxt = S_FINISH;
                end else if (w_wr_ok) begin
                    wf_rd_o     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (w_rd_ok) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rmm_we_o    = r_dir;
                rmm_re_o    = !r_dir;
                w_state_nxt = S_ACCEPT;
            end
            S_ACCEPT: begin
                if (!rmm_idle_i) w_state_nxt = S_ACTIVE;
                else if (w_tmo)  w_state_nxt = S_FINISH;
            end
            S_ACTIVE: begin
                if (rmm_err_i)       w_state_nxt = S_FINISH;
                else if (rmm_idle_i) w_state_nxt = !r_dir ? S_STORE : (w_last ? S_FINISH : S_FETCH);
                else if (w_tmo)      w_state_nxt = S_FINISH;
            end
            S_STORE: begin
                rf_wr_o     = 1'b1;
                w_state_nxt = w_last ? S_FINISH : S_FETCH;
            end
            S_FINISH: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_dir   <= 1'b0;
            r_abort <= 1'b0;
            r_addr  <= '0;
            r_wdat  <= '0;
            r_rdat  <= '0;
            r_len   <= '0;
            r_words <= '0;
            r_err   <= '0;
            r_tmr   <= '0;
        end else begin
            // Abort is only remembered while a transfer is live.
            if (r_state == S_IDLE || r_state == S_FINISH) r_abort <= 1'b0;
            else if (cmd_abort_i)                         r_abort <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (cmd_start_i) begin
                        r_dir   <= cmd_dir_i;
                        r_addr  <= cmd_addr_i;
                        r_len   <= cmd_len_i;
                        r_words <= '0;
                        r_err   <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_abort)      r_err  <= 2'd3;
                    else if (w_wr_ok) r_wdat <= wf_dat_i;
                end
                S_ISSUE: r_tmr <= TMR_LOAD;
                S_ACCEPT: begin
                    if (!rmm_idle_i) r_tmr <= TMR_LOAD;
                    else if (w_tmo)  r_err <= 2'd2;
                    else             r_tmr <= r_tmr - TMR_ONE;
                end
                S_ACTIVE: begin
                    if (rmm_err_i) begin
                        r_err <= 2'd1;
                    end else if (rmm_idle_i) begin
                        if (r_dir) begin
                            r_words <= r_words + LEN_W'(1);
                            r_addr  <= r_addr + 32'd4;
                        end else begin
                            r_rdat  <= rmm_data_i;
                        end
                    end else if (w_tmo) begin
                        r_err <= 2'd2;
                    end else begin
                        r_tmr <= r_tmr - TMR_ONE;
                    end
                end
                S_STORE: begin
                    r_words <= r_words + LEN_W'(1);
                    r_addr  <= r_addr + 32'd4;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aud_rmm_seq.md
Name: aud_rmm_seq

Overview:
- Sequences multi-word RMM (remote memory monitor) block transfers over the AUD port, one 32-bit word at a time.
- Takes a start command with address, word count and direction.
- Writes: pulls words from the host write FIFO and drives them into the RMM engine. Reads: pushes words returned by the engine into the host read FIFO.
- Sits between the wishbone register file, the two host FIFOs and the RMM engine. Replaces ad-hoc per-word strobing with a checked handshake, timeout and abort.

Parameters:
- LEN_W, 16, width of word-count fields.
- TIMEOUT, 1024, max cycles allowed per handshake phase (engine accept, engine complete) before a timeout error. Must be ≥2.
- TMR_W, 11, timeout counter width. Must satisfy 2^TMR_W > TIMEOUT.

Ports:
- clk_sys_i in 1: system clock; all logic on rising edge.
- rst_n_i in 1: asynchronous active-low reset.
- cmd_start_i in 1: one-cycle start pulse; ignored while busy_o=1.
- cmd_dir_i in 1: 1=write to target, 0=read from target; sampled at start.
- cmd_addr_i in 32: first word address; sampled at start.
- cmd_len_i in LEN_W: number of words; sampled at start.
- cmd_abort_i in 1: level or pulse; requests stop at next word boundary.
- busy_o out 1: transfer in progress.
- done_o out 1: one-cycle pulse when a transfer ends (any reason).
- err_code_o out 2: 0=ok, 1=engine error, 2=timeout, 3=aborted. Held until next accepted start.
- words_done_o out LEN_W: words completed in the current or last transfer.
- wf_dat_i in 32: write FIFO head data (first-word-fall-through).
- wf_empty_i in 1: write FIFO empty.
- wf_rd_o out 1: write FIFO pop pulse.
- rf_dat_o out 32: read FIFO push data.
- rf_full_i in 1: read FIFO full.
- rf_wr_o out 1: read FIFO push pulse.
- rmm_addr_o out 32: engine word address.
- rmm_data_o out 32: engine write data.
- rmm_we_o out 1: engine write strobe, one cycle.
- rmm_re_o out 1: engine read strobe, one cycle.
- rmm_data_i in 32: engine read data, valid when rmm_idle_i returns high.
- rmm_idle_i in 1: engine idle/ready.
- rmm_err_i in 1: engine error, sampled during the active phase.

Behaviour:
- Reset (async, rst_n_i=0): all outputs and registers 0; state IDLE.
- FSM states: IDLE, FETCH, ISSUE, ACCEPT, ACTIVE, STORE, FINISH.
- IDLE:
  - On cmd_start_i: latch dir, addr, len; clear words_done_o and err_code_o; busy_o=1 from the next cycle.
  - If len=0, go to FINISH; otherwise go to FETCH.
- FETCH (word boundary):
  - If abort is pending, set err_code_o=3 and go to FINISH.
  - Write: wait for !wf_empty_i && rmm_idle_i. Then pulse wf_rd_o, latch rmm_data_o<=wf_dat_i, go to ISSUE.
  - Read: wait for !rf_full_i && rmm_idle_i, then go to ISSUE. Reserving FIFO space before issuing guarantees no push overflow.
- ISSUE: pulse rmm_we_o (write) or rmm_re_o (read) for exactly one cycle with rmm_addr_o stable; clear the timer; go to ACCEPT.
- ACCEPT:
  - Wait for rmm_idle_i=0, then go to ACTIVE with the timer cleared.
  - If the timer reaches TIMEOUT: err_code_o=2, go to FINISH.
- ACTIVE:
  - If rmm_err_i=1: err_code_o=1, go to FINISH (word not counted).
  - Else if rmm_idle_i=1: word complete. Read goes to STORE; write increments words_done_o, adds 4 to rmm_addr_o and goes to FETCH or FINISH.
  - If the timer reaches TIMEOUT: err_code_o=2, go to FINISH.
- STORE: rf_dat_o<=rmm_data_i (captured on the ACTIVE exit cycle), pulse rf_wr_o, increment words_done_o, add 4 to address, go to FETCH or FINISH.
- Next-state choice after a completed word: FINISH when words_done equals the latched len, else FETCH.
- Address wraps modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000). Word count never exceeds len.
- FINISH: pulse done_o for one cycle; busy_o=0 from the next cycle; return to IDLE.
- Abort:
  - cmd_abort_i sets a pending flag while busy. The flag is cleared on entering IDLE and on start.
  - Abort never interrupts ACCEPT, ACTIVE or STORE; the in-flight word completes and is counted.
  - Abort takes effect only if words remain. If the last word completes, result is ok (code 0).
- Simultaneous events:
  - rmm_err_i and rmm_idle_i high in the same ACTIVE cycle: error wins.
  - Timeout and completion in the same cycle: completion wins.
  - cmd_start_i and cmd_abort_i together in IDLE: start accepted, abort ignored.
- Reset mid-transfer: immediate return to IDLE, no done_o pulse. FIFO and engine state are the owner's responsibility.
- Strobes wf_rd_o, rf_wr_o, rmm_we_o and rmm_re_o are never asserted outside their named states.

Test Plan:
- Write of 3 words, addr 0x1000, FIFO preloaded 0xA,0xB,0xC; engine idle drops 2 cycles after strobe, returns after 5 -> three rmm_we_o pulses at addr 0x1000/0x1004/0x1008 with data A/B/C, 3 wf_rd_o pulses, words_done_o=3, err_code_o=0, one done_o.
- Read of 2 words at 0xFFFFFFFC, engine returns 0x11,0x22 -> rmm_re_o at 0xFFFFFFFC then 0x00000000, rf_wr_o pushes 0x11,0x22, code 0.
- Read of 4 words with rf_full_i held high for 10 cycles before word 2 -> no rmm_re_o issued while full; completes with 4 pushes, code 0.
- Write of 5 words, rmm_err_i pulsed during word 3 ACTIVE -> done_o, err_code_o=1, words_done_o=2, no fourth strobe.
- Engine never drops idle (TIMEOUT=8) -> done_o 8 cycles after the strobe, err_code_o=2, words_done_o=0. Separately, len=0 start -> done_o with no strobes, code 0.
- Abort pulsed during word 2 ACTIVE of a 6-word write -> word 2 completes, done_o, err_code_o=3, words_done_o=2. Start while busy is ignored; asserting rst_n_i mid-ACTIVE clears busy_o asynchronously with no done_o.
